pc_unit: RTL and testbench

Parametrised program-counter unit for the multicycle CPU, replacing the bare PC register. Holds the PC, computes the next PC from a selectable source (sequential, branch, jump, register, return-address stack, exception vector), and keeps a small return-address stack (RAS) for call/return. It also traps misaligned targets to the exception vector. Sits between the control unit (PCWre, PCSrc, Push) and instruction memory (PCOUT).

---
 rtl/pc_pkg.sv | 16 +
 rtl/ras_stack.sv | 69 ++++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encodings
// and the default exception vector.
package pc_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'd0,
    PCSRC_BR  = 3'd1,
    PCSRC_J   = 3'd2,
    PCSRC_REG = 3'd3,
    PCSRC_RET = 3'd4,
    PCSRC_EXC = 3'd5
  } pcsrc_e;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0180;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer addressed by a top pointer, with a
// saturating occupancy count so that pushing onto a full stack drops the oldest entry.
module ras_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, wr_ptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic              pop_ok;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top    = mem_q[ptr_q];
  assign pop_ok = pop & ~empty;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (pop_ok && push) begin
      // Replace the entry being returned through; depth is unchanged.
      wr_en = 1'b1;
    end else if (pop_ok) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push) begin
      // When full, ptr+1 wraps onto the oldest entry.
      ptr_d  = ptr_q + PTR_W'(1);
      wr_ptr = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK) begin
        if (wr_en && !RST && (wr_ptr == PTR_W'(gi))) mem_q[gi] <= wdata;
      end
    end
  endgenerate

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, misaligned-target trap, PC register,
// and the return-address stack used by call/return.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [31:0]       EXC_VEC   = EXC_VEC_DEFAULT,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PCWre,
  input  logic [2:0]        PCSrc,
  input  logic [15:0]       Imm,
  input  logic [25:0]       JTarget,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic              Push,
  output logic [ADDR_W-1:0] PCOUT,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              MisalignErr,
  output logic [ADDR_W-1:0] BadAddr
);

  localparam logic [ADDR_W-1:0] EXC_ADDR = ADDR_W'(EXC_VEC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bad_addr_q;
  logic              merr_q;
  logic [ADDR_W-1:0] cand;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] ras_top;
  logic              hold;
  logic              pc_update;
  logic              trap;
  logic              ras_push, ras_pop;

  assign PCPlus4 = pc_q + ADDR_W'(4);
  assign br_off  = {{(ADDR_W-18){Imm[15]}}, Imm, 2'b00};

  always_comb begin
    cand = PCPlus4;
    hold = 1'b0;
    case (PCSrc)
      PCSRC_SEQ: cand = PCPlus4;
      PCSRC_BR:  cand = PCPlus4 + br_off;
      PCSRC_J:   cand = {PCPlus4[ADDR_W-1:28], JTarget, 2'b00};
      PCSRC_REG: cand = RegTarget;
      PCSRC_RET: cand = RasEmpty ? RegTarget : ras_top;
      PCSRC_EXC: cand = EXC_ADDR;
      default:   hold = 1'b1;
    endcase
  end

  assign pc_update = PCWre & ~hold;
  assign trap      = pc_update & (cand[1:0] != 2'b00);
  assign pc_d      = trap ? EXC_ADDR : cand;
  assign ras_push  = PCWre & Push;
  assign ras_pop   = PCWre & (PCSrc == PCSRC_RET) & ~RasEmpty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      bad_addr_q <= '0;
      merr_q     <= 1'b0;
    end else begin
      // Error flag is a single-cycle pulse, so it reloads every edge.
      merr_q <= trap;
      if (pc_update) pc_q <= pc_d;
      if (trap) bad_addr_q <= cand;
    end
  end

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .CLK  (CLK),
    .RST  (RST),
    .push (ras_push),
    .pop  (ras_pop),
    .wdata(PCPlus4),
    .top  (ras_top),
    .empty(RasEmpty),
    .full (RasFull)
  );

  assign PCOUT       = pc_q;
  assign MisalignErr = merr_q;
  assign BadAddr     = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic,
// compared against a queue-based reference model of the PC and return stack.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCWre = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic [15:0] Imm = 16'd0;
  logic [25:0] JTarget = 26'd0;
  logic [31:0] RegTarget = 32'd0;
  logic        Push = 1'b0;
  logic [31:0] PCOUT, PCPlus4, BadAddr;
  logic        RasEmpty, RasFull, MisalignErr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc  = 32'd0;
  logic [31:0] m_bad = 32'd0;
  logic        m_err = 1'b0;
  logic [31:0] m_ras[$];

  localparam int DEPTH = 4;
  localparam logic [31:0] EXC = 32'h0000_0180;

  pc_unit #(
    .ADDR_W   (32),
    .RESET_VEC(32'd0),
    .EXC_VEC  (32'h0000_0180),
    .RAS_DEPTH(4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .Imm        (Imm),
    .JTarget    (JTarget),
    .RegTarget  (RegTarget),
    .Push       (Push),
    .PCOUT      (PCOUT),
    .PCPlus4    (PCPlus4),
    .RasEmpty   (RasEmpty),
    .RasFull    (RasFull),
    .MisalignErr(MisalignErr),
    .BadAddr    (BadAddr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pcout"},   PCOUT,               m_pc);
    check({tag, ".pcplus4"}, PCPlus4,             m_pc + 32'd4);
    check({tag, ".empty"},   {31'd0, RasEmpty},   {31'd0, m_ras.size() == 0});
    check({tag, ".full"},    {31'd0, RasFull},    {31'd0, m_ras.size() == DEPTH});
    check({tag, ".merr"},    {31'd0, MisalignErr}, {31'd0, m_err});
    check({tag, ".badaddr"}, BadAddr,             m_bad);
  endtask

  task automatic model_reset();
    m_pc  = 32'd0;
    m_bad = 32'd0;
    m_err = 1'b0;
    m_ras.delete();
  endtask

  // One architectural step of the PC unit, from the rules of operation.
  task automatic model_step(input logic wre, input logic [2:0] src, input logic [15:0] imm,
                            input logic [25:0] jt, input logic [31:0] rt, input logic psh);
    logic [31:0] p4;
    logic [31:0] cand;
    logic        hold;
    logic        pop;
    p4    = m_pc + 32'd4;
    m_err = 1'b0;
    if (!wre) return;
    hold = 1'b0;
    cand = p4;
    case (src)
      3'd0: cand = p4;
      3'd1: cand = p4 + 32'(int'($signed(imm)) * 4);
      3'd2: cand = {p4[31:28], jt, 2'b00};
      3'd3: cand = rt;
      3'd4: cand = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : rt;
      3'd5: cand = EXC;
      default: hold = 1'b1;
    endcase
    pop = (src == 3'd4) && (m_ras.size() > 0);
    if (pop && psh) m_ras[m_ras.size()-1] = p4;
    else if (pop) void'(m_ras.pop_back());
    else if (psh) begin
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(p4);
    end
    if (!hold) begin
      if (cand[1:0] != 2'b00) begin
        m_pc  = EXC;
        m_bad = cand;
        m_err = 1'b1;
      end else begin
        m_pc = cand;
      end
    end
  endtask

  // Starts and ends at a falling edge.
  task automatic cyc(input string tag, input logic wre, input logic [2:0] src,
                     input logic [15:0] imm, input logic [25:0] jt,
                     input logic [31:0] rt, input logic psh);
    PCWre = wre; PCSrc = src; Imm = imm; JTarget = jt; RegTarget = rt; Push = psh;
    model_step(wre, src, imm, jt, rt, psh);
    @(posedge CLK);
    #1;
    $display("txn %s wre=%0d src=%0d push=%0d pc=0x%08h", tag, wre, src, psh, PCOUT);
    check_state(tag);
    @(negedge CLK);
  endtask

  task automatic go(input logic [31:0] target);
    cyc("goto", 1'b1, 3'd3, 16'd0, 26'd0, target, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    check_state("reset");

    // Asynchronous reset mid-cycle, with a pending update driven
    go(32'h40);
    check("pre_rst", PCOUT, 32'h40);
    PCWre = 1'b1; PCSrc = 3'd0; Push = 1'b1;
    #2 RST = 1'b1;
    #1;
    check("async_rst.pc", PCOUT, 32'h0);
    check("async_rst.empty", {31'd0, RasEmpty}, 32'd1);
    check("async_rst.merr", {31'd0, MisalignErr}, 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; Push = 1'b0; PCWre = 1'b0;
    #1 check_state("after_rst");
    @(negedge CLK);

    // Sequential, branch, hold
    go(32'h100);
    cyc("seq", 1'b1, 3'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("seq.val", PCOUT, 32'h104);
    cyc("br_back", 1'b1, 3'd1, 16'hFFFE, 26'd0, 32'd0, 1'b0);
    check("br.val", PCOUT, 32'h100);
    for (int i = 0; i < 3; i++) cyc("wre_low", 1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("hold.val", PCOUT, 32'h100);
    cyc("src6_hold", 1'b1, 3'd6, 16'd0, 26'd0, 32'd0, 1'b0);
    check("src6.val", PCOUT, 32'h100);

    // Jump and wrap-around
    go(32'h1000_0000);
    cyc("jump", 1'b1, 3'd2, 16'd0, 26'h3, 32'd0, 1'b0);
    check("jump.val", PCOUT, 32'h1000_000C);
    go(32'hFFFF_FFFC);
    cyc("wrap", 1'b1, 3'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("wrap.val", PCOUT, 32'h0);

    // RAS fill, overflow, drain, empty fallback
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc("push", 1'b1, 3'd3, 16'd0, 26'd0, 32'((i + 1) * 16), 1'b1);
    check("ras.full", {31'd0, RasFull}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc("ret", 1'b1, 3'd4, 16'd0, 26'd0, 32'h999, 1'b0);
      check("ret.val", PCOUT, 32'h44 - 32'(i * 16));
    end
    check("ras.empty", {31'd0, RasEmpty}, 32'd1);
    cyc("ret_empty", 1'b1, 3'd4, 16'd0, 26'd0, 32'h200, 1'b0);
    check("ret_empty.val", PCOUT, 32'h200);

    // Simultaneous push and pop
    go(32'h7C);
    cyc("push80", 1'b1, 3'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    go(32'h300);
    cyc("pushpop", 1'b1, 3'd4, 16'd0, 26'd0, 32'd0, 1'b1);
    check("pushpop.val", PCOUT, 32'h80);
    cyc("ret_new_top", 1'b1, 3'd4, 16'd0, 26'd0, 32'h500, 1'b0);
    check("newtop.val", PCOUT, 32'h304);

    // Misaligned register target
    go(32'h100);
    cyc("misalign", 1'b1, 3'd3, 16'd0, 26'd0, 32'h102, 1'b0);
    check("misalign.pc", PCOUT, 32'h180);
    check("misalign.bad", BadAddr, 32'h102);
    check("misalign.err", {31'd0, MisalignErr}, 32'd1);
    cyc("misalign_clr", 1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("misalign.clr", {31'd0, MisalignErr}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        wre;
      logic [2:0]  src;
      logic [31:0] rt;
      wre = ($urandom_range(0, 9) < 8);
      src = 3'($urandom_range(0, 7));
      rt  = $urandom;
      if ($urandom_range(0, 9) < 8) rt[1:0] = 2'b00;
      cyc("rand", wre, src, 16'($urandom), 26'($urandom), rt, ($urandom_range(0, 9) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
